// File: rtl/abc_pkg.sv
// rtl/abc_pkg.sv - shared types and constants for the abc sweeper
package abc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_t;

    localparam logic [7:0] ABC_GOLDEN = 8'hE2;
    localparam int         NUM_CODES  = 8;

endpackage

// File: rtl/abc.sv
// rtl/abc.sv - the abc combinational block, y = a&b | ~b&c
module abc (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (~b & c);

endmodule

// File: rtl/abc_sweeper.sv
// rtl/abc_sweeper.sv - walks abc through all input codes and scores its truth table
module abc_sweeper
    import abc_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXPECTED      = ABC_GOLDEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [7:0] truth_table,
    output logic [3:0] errors,
    output logic       pass
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("abc_sweeper: SETTLE_CYCLES must be within 1..15");
    end

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_INDEX  = 3'(NUM_CODES - 1);

    sweep_state_t state_q, state_d;
    logic [2:0]   index_q, index_d;
    logic [3:0]   count_q, count_d;
    logic [7:0]   tt_q, tt_d;
    logic [3:0]   err_q, err_d;
    logic         pass_q, pass_d;
    logic         y;

    // The stimulus is the index itself: it is 0 after reset and parks at 7
    // after a sweep, which is exactly the required IDLE/DONE hold behaviour.
    assign {a, b, c} = index_q;

    abc u_abc (
        .a (a),
        .b (b),
        .c (c),
        .y (y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
            count_q <= '0;
            tt_q    <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        tt_d    = tt_q;
        err_d   = err_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tt_d    = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    index_d = '0;
                    count_d = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                count_d = count_q + 4'd1;
                if (count_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                tt_d[index_q] = y;
                if (y != EXPECTED[index_q]) begin
                    err_d = err_q + 4'd1;
                end
                if (index_q == LAST_INDEX) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 3'd1;
                    count_d = '0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                pass_d  = (err_q == 4'd0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done        = (state_q == DONE);
    assign truth_table = tt_q;
    assign errors      = err_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_abc_sweeper.sv
// tb/tb_abc_sweeper.sv - scoreboard bench for abc_sweeper across three parameter sets
module tb_abc_sweeper;

    typedef struct {
        logic [7:0] tt;
        logic [3:0] err;
        logic       ps;
        longint     t;
    } exp_t;

    localparam int         SC0 = 2, SC1 = 2, SC2 = 1;
    localparam logic [7:0] EX0 = 8'hE2, EX1 = 8'hFF, EX2 = 8'hE2;

    logic       clk;
    logic       rst [3];
    logic       st  [3];
    logic       bsy [3];
    logic       dn  [3];
    logic       a   [3];
    logic       b   [3];
    logic       c   [3];
    logic [7:0] tt  [3];
    logic [3:0] er  [3];
    logic       ps  [3];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sbq [3][$];
    logic pend [3];
    logic pend_pass [3];

    abc_sweeper #(.SETTLE_CYCLES(SC0), .EXPECTED(EX0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .start(st[0]), .busy(bsy[0]), .done(dn[0]),
        .a(a[0]), .b(b[0]), .c(c[0]), .truth_table(tt[0]), .errors(er[0]), .pass(ps[0])
    );
    abc_sweeper #(.SETTLE_CYCLES(SC1), .EXPECTED(EX1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .busy(bsy[1]), .done(dn[1]),
        .a(a[1]), .b(b[1]), .c(c[1]), .truth_table(tt[1]), .errors(er[1]), .pass(ps[1])
    );
    abc_sweeper #(.SETTLE_CYCLES(SC2), .EXPECTED(EX2)) u_dut2 (
        .clk(clk), .reset(rst[2]), .start(st[2]), .busy(bsy[2]), .done(dn[2]),
        .a(a[2]), .b(b[2]), .c(c[2]), .truth_table(tt[2]), .errors(er[2]), .pass(ps[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_tt();
        logic [7:0] r;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            r[i] = (v[2] & v[1]) | (~v[1] & v[0]);
        end
        return r;
    endfunction

    function automatic int popcount8(input logic [7:0] x);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(x[i]);
        return n;
    endfunction

    function automatic int sc_of(input int k);
        return (k == 2) ? SC2 : ((k == 1) ? SC1 : SC0);
    endfunction

    function automatic logic [7:0] ex_of(input int k);
        return (k == 2) ? EX2 : ((k == 1) ? EX1 : EX0);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (pend[k]) begin
                check("pass_after_done", ps[k], pend_pass[k]);
                pend[k] = 1'b0;
            end
            if (dn[k] === 1'b1) begin
                check("busy_in_done", bsy[k], 0);
                if (sbq[k].size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sbq[k].pop_front();
                    check("done_time", longint'($time), e.t);
                    check("truth_table", tt[k], e.tt);
                    check("errors", er[k], e.err);
                    pend[k]      = 1'b1;
                    pend_pass[k] = e.ps;
                end
            end
        end
    end

    task automatic start_sweep(input int k);
        exp_t   e;
        longint t0;
        @(negedge clk);
        st[k] = 1'b1;
        @(posedge clk);
        t0    = longint'($time);
        e.tt  = model_tt();
        e.err = 4'(popcount8(e.tt ^ ex_of(k)));
        e.ps  = (e.err == 4'd0);
        e.t   = t0 + 10 * 8 * (sc_of(k) + 1) + 5;
        sbq[k].push_back(e);
        @(negedge clk);
        st[k] = 1'b0;
        check("accept_busy", bsy[k], 1);
        check("accept_tt_clear", tt[k], 0);
        check("accept_err_clear", er[k], 0);
        check("accept_pass_clear", ps[k], 0);
    endtask

    task automatic wait_done(input int k);
        logic seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (dn[k] === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("done_timeout", seen, 1);
    endtask

    task automatic check_zero(input int k);
        check("rst_busy", bsy[k], 0);
        check("rst_done", dn[k], 0);
        check("rst_abc", {a[k], b[k], c[k]}, 0);
        check("rst_tt", tt[k], 0);
        check("rst_err", er[k], 0);
        check("rst_pass", ps[k], 0);
    endtask

    initial begin
        logic found;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; st[k] = 1'b1; pend[k] = 1'b0; pend_pass[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_zero(k);
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; st[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check("idle_busy", bsy[k], 0);

        // nominal sweep with stimulus walk and result hold
        start_sweep(0);
        for (int n = 0; n < 24; n++) begin
            check("walk_abc", {a[0], b[0], c[0]}, n / (SC0 + 1));
            check("walk_busy", bsy[0], 1);
            @(negedge clk);
        end
        wait_done(0);
        repeat (10) begin
            @(negedge clk);
            check("hold_tt", tt[0], 8'hE2);
            check("hold_pass", ps[0], 1);
            check("hold_busy", bsy[0], 0);
            check("hold_abc", {a[0], b[0], c[0]}, 7);
        end

        // start pulses while busy must be ignored
        start_sweep(0);
        repeat (4) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (6) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0);
        repeat (30) @(negedge clk);

        // reset while settling code 3
        start_sweep(0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ({a[0], b[0], c[0]} == 3'd3 && bsy[0]) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_code3", found, 1);
        rst[0] = 1'b1;
        sbq[0].delete();
        @(negedge clk);
        check_zero(0);
        rst[0] = 1'b0;
        repeat (3) @(negedge clk);
        start_sweep(0);
        wait_done(0);
        repeat (2) @(negedge clk);

        // mismatch counting against an all-ones table
        start_sweep(1);
        wait_done(1);
        repeat (2) @(negedge clk);
        check("mismatch_pass", ps[1], 0);

        // short settle and restart in the first IDLE cycle after done
        start_sweep(2);
        wait_done(2);
        start_sweep(2);
        wait_done(2);
        repeat (3) @(negedge clk);
        check("restart_tt", tt[2], 8'hE2);

        for (int k = 0; k < 3; k++) check("sb_empty", sbq[k].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
